// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, multi-cycle EX freeze, taken-branch flush, stall counter.
// Latency: controls are combinational from fsm state and current inputs; state updates on posedge clk.
// Backpressure: none accepted; the module itself produces the pipeline backpressure via the write enables.
module idex_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_RegRt,
    input  logic             ex_MulStart,
    input  logic [4:0]       id_RegRs,
    input  logic [4:0]       id_RegRt,
    input  logic             id_UsesRt,
    input  logic             mem_BranchTaken,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_bubble,
    output logic             ex_busy,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } fsm_t;

    localparam logic [3:0]       MCNT_INIT = 4'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    fsm_t             fsm_q, fsm_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             lu_hit;

    always_comb begin
        lu_hit = ex_MemRead && (ex_RegRt != 5'd0) &&
                 ((ex_RegRt == id_RegRs) || (id_UsesRt && (ex_RegRt == id_RegRt)));
    end

    always_comb begin
        fsm_d       = fsm_q;
        mcnt_d      = mcnt_q;
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        ifid_flush  = 1'b0;
        idex_wen    = 1'b1;
        idex_bubble = 1'b0;
        ex_busy     = 1'b0;
        mul_done    = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (mem_BranchTaken) begin
                    // Wrong-path EX op and ID instruction are squashed; PC loads the target.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (ex_MulStart) begin
                    // The freeze subsumes any load-use stall raised this cycle.
                    fsm_d    = MUL_BUSY;
                    mcnt_d   = MCNT_INIT;
                    pc_wen   = 1'b0;
                    ifid_wen = 1'b0;
                    idex_wen = 1'b0;
                    ex_busy  = 1'b1;
                end else if (lu_hit) begin
                    pc_wen      = 1'b0;
                    ifid_wen    = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MUL_BUSY: begin
                pc_wen   = 1'b0;
                ifid_wen = 1'b0;
                idex_wen = 1'b0;
                ex_busy  = 1'b1;
                mcnt_d   = mcnt_q - 4'd1;
                if (mcnt_q == 4'd1) begin
                    mul_done = 1'b1;
                    fsm_d    = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_wen && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q         <= IDLE;
            mcnt_q        <= 4'd0;
            stall_count_q <= '0;
        end else begin
            fsm_q         <= fsm_d;
            mcnt_q        <= mcnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: doc/idex_hazard_ctrl.md
Name: idex_hazard_ctrl

Overview:
Pipeline hazard controller on the read side of the ID/EX pipeline register. It watches the fields the ID/EX register delivers to EX, together with the decode-stage register operands and the MEM-stage branch outcome. From these it drives the write-enable, bubble and flush controls back to the PC, IF/ID and ID/EX registers. It handles three cases: load-use stalls, multi-cycle EX operations (multiply) and taken-branch flushes, and it keeps a stall-cycle counter for performance analysis.

Parameters:
MUL_LAT, 4, cycles a multi-cycle EX op occupies EX (legal range 2..16).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset; synchronous, active-high.
ex_MemRead  input  1  ID/EX q_MemRead (instruction in EX is a load).
ex_RegRt  input  5  ID/EX q_RegRt (load destination).
ex_MulStart  input  1  instruction in EX is a multi-cycle op; valid in its first EX cycle.
id_RegRs  input  5  Rs of the instruction in ID.
id_RegRt  input  5  Rt of the instruction in ID.
id_UsesRt  input  1  ID instruction reads Rt as a source.
mem_BranchTaken  input  1  branch in MEM resolved taken.
pc_wen  output  1  PC write enable.
ifid_wen  output  1  IF/ID write enable.
ifid_flush  output  1  IF/ID loads a NOP.
idex_wen  output  1  ID/EX write enable.
idex_bubble  output  1  ID/EX loads all-zero control fields.
ex_busy  output  1  multi-cycle op in progress.
mul_done  output  1  one-cycle pulse on the last busy cycle.
stall_count  output  CNT_W  saturating count of cycles with pc_wen=0.

Behaviour:
- State registers: fsm {IDLE, MUL_BUSY}; mcnt[3:0]; stall_count. All other outputs are combinational (Mealy) from the state and the current inputs.
- Reset (rst=1 at posedge):
  - fsm=IDLE, mcnt=0, stall_count=0.
  - Outputs while fsm=IDLE with no hazard: pc_wen=1, ifid_wen=1, idex_wen=1, idex_bubble=0, ifid_flush=0, ex_busy=0, mul_done=0.
  - Reset during MUL_BUSY aborts the operation; no mul_done is issued.
- Load-use hazard (LU), evaluated in IDLE only:
  - Condition: ex_MemRead & (ex_RegRt!=0) & ((ex_RegRt==id_RegRs) | (id_UsesRt & ex_RegRt==id_RegRt)).
  - Same-cycle response: pc_wen=0, ifid_wen=0, idex_wen=1, idex_bubble=1.
  - Exactly one stall cycle; the load then advances to MEM and LU clears. No state change.
- Taken branch (BR), IDLE only:
  - ifid_flush=1, idex_bubble=1, pc_wen=1 (PC loads target), ifid_wen=1, idex_wen=1.
  - Lasts 1 cycle.
  - BR has priority over LU and over ex_MulStart: the wrong-path op is killed and MUL_BUSY is not entered.
- Multi-cycle op, IDLE & ex_MulStart & !mem_BranchTaken:
  - Next fsm=MUL_BUSY, mcnt=MUL_LAT-1.
  - In the start cycle: pc_wen=ifid_wen=idex_wen=0, ex_busy=1.
  - LU in the same cycle is masked, since the freeze covers it.
- MUL_BUSY:
  - pc_wen=ifid_wen=idex_wen=0, ex_busy=1, idex_bubble=0, ifid_flush=0.
  - mcnt decrements each cycle.
  - When mcnt==1: mul_done=1 and next fsm=IDLE.
  - Total freeze = MUL_LAT cycles including the start cycle; ID/EX resumes writing on the cycle after mul_done.
  - mem_BranchTaken and ex_MulStart are ignored here; MEM only holds bubbles.
- stall_count: +1 on each posedge where pc_wen=0 and rst=0; saturates at all-ones (no wrap).
- No output may change except through rst, the fsm or the listed inputs. No X on any output after reset.

Test Plan:
1. Reset → pc_wen=ifid_wen=idex_wen=1, idex_bubble=ifid_flush=ex_busy=mul_done=0, stall_count=0.
2. ex_MemRead=1, ex_RegRt=5, id_RegRs=5 for 1 cycle → that cycle pc_wen=0, ifid_wen=0, idex_bubble=1; next cycle (ex_MemRead=0) all enables 1; stall_count=1. Repeat with ex_RegRt=0 → no stall. Repeat with id_RegRt=5, id_UsesRt=0 → no stall.
3. ex_MulStart=1 one cycle, MUL_LAT=4 → pc_wen=0 and ex_busy=1 for exactly 4 cycles; mul_done high only in cycle 4; idex_wen returns to 1 in cycle 5; stall_count=4.
4. mem_BranchTaken=1 together with ex_MulStart=1 and an LU match → ifid_flush=1, idex_bubble=1, pc_wen=1; fsm stays IDLE (ex_busy=0 next cycle); stall_count unchanged.
5. rst asserted in cycle 2 of MUL_BUSY → next cycle IDLE, ex_busy=0, no mul_done, stall_count=0.
6. Force the stall_count near saturation (CNT_W=4 build), then hold an LU stall for 20 cycles → stall_count stops at 15 and does not wrap.
